// File: rtl/pipe_control_unit_if.sv
// Handshake bundle between the IF/ID register and the pipelined control unit.
// Master drives ID-stage fields and flush; slave returns stall and stage controls.
interface pipe_control_unit_if #(
    parameter int OP_W    = 6,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 2
);
    logic [OP_W-1:0]      op;
    logic                 id_valid;
    logic [RA_W-1:0]      id_rs;
    logic [RA_W-1:0]      id_rt;
    logic                 flush;
    logic                 stall;
    logic [ALUOP_W+1:0]   ex_ctrl;
    logic [RA_W-1:0]      ex_rt;
    logic [2:0]           mem_ctrl;
    logic [1:0]           wb_ctrl;
    logic                 illegal;

    modport master (
        output op, id_valid, id_rs, id_rt, flush,
        input  stall, ex_ctrl, ex_rt, mem_ctrl, wb_ctrl, illegal
    );

    modport slave (
        input  op, id_valid, id_rs, id_rt, flush,
        output stall, ex_ctrl, ex_rt, mem_ctrl, wb_ctrl, illegal
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined main decoder: decodes ID opcode, carries EX/M/WB controls
// through ID/EX, EX/MEM, MEM/WB, and raises a one-cycle load-use stall.
module pipe_control_unit #(
    parameter int OP_W      = 6,
    parameter int RA_W      = 5,
    parameter int ALUOP_W   = 2,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    pipe_control_unit_if.slave bus
);
    localparam int EX_W = ALUOP_W + 2;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);

    logic [EX_W-1:0] dec_ex;
    logic [2:0]      dec_m;
    logic [1:0]      dec_wb;
    logic            dec_ill;

    logic [EX_W-1:0] ex_q;
    logic [RA_W-1:0] ex_rt_q;
    logic [2:0]      ex_m_q;
    logic [1:0]      ex_wb_q;
    logic            ill_q;
    logic [2:0]      mem_q;
    logic [1:0]      mem_wb_q;
    logic [1:0]      wb_q;
    logic            stall_c;

    // {RegDst, ALUOp, ALUSrc} | {Branch, MemRead, MemWrite} | {RegWrite, MemtoReg}
    always_comb begin
        dec_ex  = '0;
        dec_m   = '0;
        dec_wb  = '0;
        dec_ill = 1'b0;
        unique case (1'b1)
            (bus.op == OP_R): begin
                dec_ex = {1'b1, ALUOP_W'(2'b10), 1'b0};
                dec_wb = 2'b10;
            end
            (bus.op == OP_LW): begin
                dec_ex = {1'b0, ALUOP_W'(2'b00), 1'b1};
                dec_m  = 3'b010;
                dec_wb = 2'b11;
            end
            (bus.op == OP_SW): begin
                dec_ex = {1'b0, ALUOP_W'(2'b00), 1'b1};
                dec_m  = 3'b001;
            end
            (bus.op == OP_BEQ): begin
                dec_ex = {1'b0, ALUOP_W'(2'b01), 1'b0};
                dec_m  = 3'b100;
            end
            (bus.op == OP_ADDI): begin
                dec_ex = {1'b0, ALUOP_W'(2'b00), 1'b1};
                dec_wb = 2'b10;
            end
            (bus.op == OP_SLTI): begin
                dec_ex = {1'b0, ALUOP_W'(2'b11), 1'b1};
                dec_wb = 2'b10;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Load in EX whose rt feeds the ID instruction; $0 never creates a hazard.
    always_comb begin
        stall_c = HAZARD_EN & bus.id_valid & ~bus.flush & ex_m_q[1]
                & (ex_rt_q != '0)
                & ((ex_rt_q == bus.id_rs) | (ex_rt_q == bus.id_rt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            ex_rt_q <= '0;
            ex_m_q  <= '0;
            ex_wb_q <= '0;
            ill_q   <= 1'b0;
        end else if (bus.flush || !bus.id_valid) begin
            ex_q    <= '0;
            ex_rt_q <= '0;
            ex_m_q  <= '0;
            ex_wb_q <= '0;
            ill_q   <= 1'b0;
        end else if (stall_c) begin
            ex_q    <= '0;
            ex_rt_q <= bus.id_rt;
            ex_m_q  <= '0;
            ex_wb_q <= '0;
            ill_q   <= 1'b0;
        end else begin
            ex_q    <= dec_ex;
            ex_rt_q <= bus.id_rt;
            ex_m_q  <= dec_m;
            ex_wb_q <= dec_wb;
            ill_q   <= dec_ill;
        end
    end

    // MEM/WB is never flushed: the branch in MEM is committed.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            mem_q    <= '0;
            mem_wb_q <= '0;
        end else begin
            mem_q    <= ex_m_q;
            mem_wb_q <= ex_wb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= mem_wb_q;
        end
    end

    assign bus.stall    = stall_c;
    assign bus.ex_ctrl  = ex_q;
    assign bus.ex_rt    = ex_rt_q;
    assign bus.mem_ctrl = mem_q;
    assign bus.wb_ctrl  = wb_q;
    assign bus.illegal  = ill_q;
endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit; a second instance has the
// load-use stall logic disabled.
module tb_pipe_control_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_control_unit_if bus_a ();
    pipe_control_unit_if bus_b ();

    pipe_control_unit #(.HAZARD_EN(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    pipe_control_unit #(.HAZARD_EN(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] op, input logic v,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic fl);
        bus_a.op = op; bus_a.id_valid = v;
        bus_a.id_rs = rs; bus_a.id_rt = rt; bus_a.flush = fl;
        bus_b.op = op; bus_b.id_valid = v;
        bus_b.id_rs = rs; bus_b.id_rt = rt; bus_b.flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(6'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus_a.ex_ctrl !== 4'b0) begin
            errors++;
            $display("FAIL reset_ex got %b exp 0000", bus_a.ex_ctrl);
        end
        checks++;
        if (bus_a.mem_ctrl !== 3'b0 || bus_a.wb_ctrl !== 2'b0) begin
            errors++;
            $display("FAIL reset_memwb got %b/%b exp 000/00",
                     bus_a.mem_ctrl, bus_a.wb_ctrl);
        end
        checks++;
        if (bus_a.ex_rt !== 5'd0 || bus_a.illegal !== 1'b0
            || bus_a.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_misc got rt=%0d ill=%b st=%b exp 0/0/0",
                     bus_a.ex_rt, bus_a.illegal, bus_a.stall);
        end
    endtask

    task automatic test_rtype();
        do_reset();
        drive(6'b000000, 1'b1, 5'd1, 5'd2, 1'b0);
        tick();
        checks++;
        if (bus_a.ex_ctrl !== 4'b1100 || bus_a.ex_rt !== 5'd2) begin
            errors++;
            $display("FAIL rtype_ex got %b rt=%0d exp 1100 rt=2",
                     bus_a.ex_ctrl, bus_a.ex_rt);
        end
        drive(6'b000000, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        checks++;
        if (bus_a.mem_ctrl !== 3'b000 || bus_a.ex_ctrl !== 4'b0) begin
            errors++;
            $display("FAIL rtype_mem got %b ex=%b exp 000 ex=0000",
                     bus_a.mem_ctrl, bus_a.ex_ctrl);
        end
        tick();
        checks++;
        if (bus_a.wb_ctrl !== 2'b10) begin
            errors++;
            $display("FAIL rtype_wb got %b exp 10", bus_a.wb_ctrl);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(6'b100011, 1'b1, 5'd0, 5'd5, 1'b0);
        tick();
        checks++;
        if (bus_a.ex_ctrl !== 4'b0001 || bus_a.ex_rt !== 5'd5) begin
            errors++;
            $display("FAIL lu_lw_ex got %b rt=%0d exp 0001 rt=5",
                     bus_a.ex_ctrl, bus_a.ex_rt);
        end
        drive(6'b000000, 1'b1, 5'd5, 5'd3, 1'b0);
        checks++;
        if (bus_a.stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall got %b exp 1", bus_a.stall);
        end
        checks++;
        if (bus_b.stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_hazard_off got %b exp 0", bus_b.stall);
        end
        tick();
        checks++;
        if (bus_a.ex_ctrl !== 4'b0 || bus_a.ex_rt !== 5'd3
            || bus_a.mem_ctrl !== 3'b010) begin
            errors++;
            $display("FAIL lu_bubble got ex=%b rt=%0d mem=%b exp 0000 3 010",
                     bus_a.ex_ctrl, bus_a.ex_rt, bus_a.mem_ctrl);
        end
        checks++;
        if (bus_a.stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall_clear got %b exp 0", bus_a.stall);
        end
        tick();
        checks++;
        if (bus_a.ex_ctrl !== 4'b1100 || bus_a.wb_ctrl !== 2'b11) begin
            errors++;
            $display("FAIL lu_resume got ex=%b wb=%b exp 1100 11",
                     bus_a.ex_ctrl, bus_a.wb_ctrl);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(6'b100011, 1'b1, 5'd0, 5'd0, 1'b0);
        tick();
        drive(6'b000000, 1'b1, 5'd0, 5'd0, 1'b0);
        checks++;
        if (bus_a.stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_stall got %b exp 0", bus_a.stall);
        end
        tick();
        checks++;
        if (bus_a.ex_ctrl !== 4'b1100) begin
            errors++;
            $display("FAIL zero_reg_ex got %b exp 1100", bus_a.ex_ctrl);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(6'b001000, 1'b1, 5'd1, 5'd7, 1'b0);
        tick();
        drive(6'b000100, 1'b1, 5'd1, 5'd2, 1'b0);
        tick();
        drive(6'b100011, 1'b1, 5'd0, 5'd5, 1'b0);
        tick();
        checks++;
        if (bus_a.mem_ctrl !== 3'b100 || bus_a.ex_ctrl !== 4'b0001
            || bus_a.wb_ctrl !== 2'b10) begin
            errors++;
            $display("FAIL flush_setup got mem=%b ex=%b wb=%b exp 100 0001 10",
                     bus_a.mem_ctrl, bus_a.ex_ctrl, bus_a.wb_ctrl);
        end
        drive(6'b000000, 1'b1, 5'd5, 5'd6, 1'b1);
        checks++;
        if (bus_a.stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall got %b exp 0", bus_a.stall);
        end
        tick();
        checks++;
        if (bus_a.ex_ctrl !== 4'b0 || bus_a.mem_ctrl !== 3'b0
            || bus_a.ex_rt !== 5'd0) begin
            errors++;
            $display("FAIL flush_zero got ex=%b mem=%b rt=%0d exp 0 0 0",
                     bus_a.ex_ctrl, bus_a.mem_ctrl, bus_a.ex_rt);
        end
        checks++;
        if (bus_a.wb_ctrl !== 2'b00) begin
            errors++;
            $display("FAIL flush_wb_beq got %b exp 00", bus_a.wb_ctrl);
        end
        drive(6'b000000, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        checks++;
        if (bus_a.wb_ctrl !== 2'b00) begin
            errors++;
            $display("FAIL flush_lw_killed got %b exp 00", bus_a.wb_ctrl);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(6'b111111, 1'b1, 5'd1, 5'd2, 1'b0);
        tick();
        checks++;
        if (bus_a.illegal !== 1'b1 || bus_a.ex_ctrl !== 4'b0) begin
            errors++;
            $display("FAIL ill_set got ill=%b ex=%b exp 1 0000",
                     bus_a.illegal, bus_a.ex_ctrl);
        end
        drive(6'b001000, 1'b1, 5'd1, 5'd3, 1'b0);
        tick();
        checks++;
        if (bus_a.illegal !== 1'b0 || bus_a.ex_ctrl !== 4'b0001
            || bus_a.mem_ctrl !== 3'b0) begin
            errors++;
            $display("FAIL ill_addi got ill=%b ex=%b mem=%b exp 0 0001 000",
                     bus_a.illegal, bus_a.ex_ctrl, bus_a.mem_ctrl);
        end
        drive(6'b111111, 1'b0, 5'd1, 5'd3, 1'b0);
        tick();
        checks++;
        if (bus_a.illegal !== 1'b0 || bus_a.wb_ctrl !== 2'b00) begin
            errors++;
            $display("FAIL ill_invalid got ill=%b wb=%b exp 0 00",
                     bus_a.illegal, bus_a.wb_ctrl);
        end
    endtask

    task automatic test_sw_beq();
        do_reset();
        drive(6'b101011, 1'b1, 5'd1, 5'd2, 1'b0);
        tick();
        drive(6'b000100, 1'b1, 5'd3, 5'd4, 1'b0);
        tick();
        checks++;
        if (bus_a.ex_ctrl !== 4'b0010 || bus_a.mem_ctrl !== 3'b001) begin
            errors++;
            $display("FAIL sw_beq got ex=%b mem=%b exp 0010 001",
                     bus_a.ex_ctrl, bus_a.mem_ctrl);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive(6'b100011, 1'b1, 5'd1, 5'd8, 1'b0);
        tick();
        drive(6'b101011, 1'b1, 5'd1, 5'd9, 1'b0);
        tick();
        drive(6'b000000, 1'b1, 5'd2, 5'd3, 1'b0);
        tick();
        checks++;
        if (bus_a.wb_ctrl !== 2'b11 || bus_a.mem_ctrl !== 3'b001) begin
            errors++;
            $display("FAIL mid_inflight got wb=%b mem=%b exp 11 001",
                     bus_a.wb_ctrl, bus_a.mem_ctrl);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus_a.ex_ctrl !== 4'b0 || bus_a.mem_ctrl !== 3'b0
            || bus_a.wb_ctrl !== 2'b0 || bus_a.ex_rt !== 5'd0
            || bus_a.illegal !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got ex=%b mem=%b wb=%b rt=%0d exp zeros",
                     bus_a.ex_ctrl, bus_a.mem_ctrl, bus_a.wb_ctrl, bus_a.ex_rt);
        end
        drive(6'b001010, 1'b1, 5'd1, 5'd4, 1'b0);
        tick();
        checks++;
        if (bus_a.ex_ctrl !== 4'b0111) begin
            errors++;
            $display("FAIL mid_slti_ex got %b exp 0111", bus_a.ex_ctrl);
        end
        drive(6'b000000, 1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        checks++;
        if (bus_a.wb_ctrl !== 2'b10) begin
            errors++;
            $display("FAIL mid_slti_wb got %b exp 10", bus_a.wb_ctrl);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(6'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        test_reset();
        test_rtype();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_illegal();
        test_sw_beq();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
